// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Address checking lives here so the bench-visible rule has one home.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam logic [31:0] DMEM_BASE_DEFAULT = 32'h10010000;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  function automatic logic addr_err(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int unsigned depth
  );
    logic [31:0] lim;
    lim = base + (depth << 2);
    return (addr[1:0] != 2'b00) || (addr < base) || (addr >= lim);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with byte-enable writes and registered reads.
// Contents are never reset.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory side of the CPU load/store port: one request at a time,
// WAIT_CYCLES wait states, response held until the requester takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = DMEM_BASE_DEFAULT,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IW = $clog2(DEPTH_WORDS);

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic        err_q, err_d;
  logic        rd_q, rd_d;
  logic        rdy_en_q;

  req_t          cur;
  logic          cur_err;
  logic          accept;
  logic          commit;
  logic [IW-1:0] idx;
  logic [31:0]   arr_rdata;

  assign req_ready = (state_q == IDLE) && rdy_en_q;
  assign accept    = req_valid && req_ready;

  // With zero wait states the commit edge is the accept edge,
  // so the array must see the incoming request directly.
  always_comb begin
    cur = req_q;
    if (state_q == IDLE) begin
      cur = '{we: req_we, addr: req_addr,
              wdata: req_wdata, be: req_be};
    end
  end

  assign cur_err = addr_err(cur.addr, ADDR_BASE, DEPTH_WORDS);
  assign idx     = IW'((cur.addr - ADDR_BASE) >> 2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    err_d   = err_q;
    rd_d    = rd_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          req_d = cur;
          err_d = cur_err;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (commit) rd_d = !cur.we && !cur_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      err_q    <= 1'b0;
      rd_q     <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
      rdy_en_q <= 1'b1;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IW         (IW)
  ) u_array (
    .clk  (clk),
    .en   (commit && !cur_err),
    .we   (cur.we),
    .be   (cur.be),
    .idx  (idx),
    .wdata(cur.wdata),
    .rdata(arr_rdata)
  );

  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && rd_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: index 0 has no wait
// states, index 1 has two.
module tb_dmem_responder;

  localparam logic [31:0] B = 32'h10010000;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        rq_v     [2];
  logic        rq_rdy   [2];
  logic        rq_we    [2];
  logic [31:0] rq_addr  [2];
  logic [31:0] rq_wdata [2];
  logic [3:0]  rq_be    [2];
  logic        rs_v     [2];
  logic        rs_rdy   [2];
  logic [31:0] rs_data  [2];
  logic        rs_err   [2];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   acc1  = 0;
  exp_t exp_q [$];

  dmem_responder #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(rq_v[0]), .req_ready(rq_rdy[0]),
    .req_we(rq_we[0]), .req_addr(rq_addr[0]),
    .req_wdata(rq_wdata[0]), .req_be(rq_be[0]),
    .rsp_valid(rs_v[0]), .rsp_ready(rs_rdy[0]),
    .rsp_rdata(rs_data[0]), .rsp_err(rs_err[0])
  );

  dmem_responder #(.WAIT_CYCLES(2)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(rq_v[1]), .req_ready(rq_rdy[1]),
    .req_we(rq_we[1]), .req_addr(rq_addr[1]),
    .req_wdata(rq_wdata[1]), .req_be(rq_be[1]),
    .rsp_valid(rs_v[1]), .rsp_ready(rs_rdy[1]),
    .rsp_rdata(rs_data[1]), .rsp_err(rs_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (rq_v[1] && rq_rdy[1]) acc1++;

  function automatic logic [31:0] merge(
    input logic [31:0] o, input logic [31:0] n, input logic [3:0] be
  );
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  // Drives one request with rsp_ready=1; lat counts cycles from the
  // accepting cycle to the first cycle with rsp_valid high.
  task automatic xfer(
    input int s, input logic we, input logic [31:0] addr,
    input logic [31:0] wd, input logic [3:0] be,
    output logic [31:0] rd, output logic er,
    output int lat, output bit ok
  );
    int n;
    ok = 1'b1; lat = 0; rd = '0; er = 1'b0;
    @(negedge clk);
    rq_v[s] = 1'b1; rq_we[s] = we; rq_addr[s] = addr;
    rq_wdata[s] = wd; rq_be[s] = be; rs_rdy[s] = 1'b1;
    n = 0;
    while (!rq_rdy[s] && n < 50) begin @(negedge clk); n++; end
    if (!rq_rdy[s]) begin ok = 1'b0; rq_v[s] = 1'b0; return; end
    @(negedge clk);
    rq_v[s] = 1'b0; lat = 1;
    while (!rs_v[s] && lat < 50) begin @(negedge clk); lat++; end
    if (!rs_v[s]) begin ok = 1'b0; return; end
    rd = rs_data[s]; er = rs_err[s];
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if ({rq_rdy[s], rs_v[s], rs_err[s], rs_data[s]} !== 35'd0) begin
        n_bad++;
        $display("FAIL reset_out[%0d]: got rdy=%b v=%b err=%b d=%h want all 0",
                 s, rq_rdy[s], rs_v[s], rs_err[s], rs_data[s]);
      end
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (rq_rdy[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL rdy_before_edge: got %b want 0", rq_rdy[1]);
    end
    @(negedge clk);
    n_cmp++;
    if (rq_rdy[0] !== 1'b1 || rq_rdy[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL rdy_after_edge: got %b%b want 11", rq_rdy[0], rq_rdy[1]);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int lat; bit ok; exp_t e;
    exp_q.push_back('{d: 32'h0, e: 1'b0});
    xfer(1, 1'b1, B + 32'h8, 32'hCAFEBABE, 4'hF, rd, er, lat, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || rd !== e.d || er !== e.e || lat != 3) begin
      n_bad++;
      $display("FAIL wr_cafe: got d=%h err=%b lat=%0d ok=%0d want d=%h err=%b lat=3",
               rd, er, lat, ok, e.d, e.e);
    end
    exp_q.push_back('{d: 32'hCAFEBABE, e: 1'b0});
    xfer(1, 1'b0, B + 32'h8, 32'h0, 4'h0, rd, er, lat, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || rd !== e.d || er !== e.e || lat != 3) begin
      n_bad++;
      $display("FAIL rd_cafe: got d=%h err=%b lat=%0d ok=%0d want d=%h err=%b lat=3",
               rd, er, lat, ok, e.d, e.e);
    end
  endtask

  task automatic test_byte_en();
    logic [31:0] rd; logic er; int lat; bit ok; exp_t e;
    xfer(1, 1'b1, B, 32'h11223344, 4'hF, rd, er, lat, ok);
    n_cmp++;
    if (!ok || er !== 1'b0 || rd !== 32'h0) begin
      n_bad++;
      $display("FAIL be_base_wr: got d=%h err=%b ok=%0d want d=0 err=0", rd, er, ok);
    end
    xfer(1, 1'b1, B, 32'hAABBCCDD, 4'b0101, rd, er, lat, ok);
    exp_q.push_back('{d: merge(32'h11223344, 32'hAABBCCDD, 4'b0101), e: 1'b0});
    xfer(1, 1'b0, B, 32'h0, 4'h0, rd, er, lat, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || rd !== e.d || er !== e.e) begin
      n_bad++;
      $display("FAIL be_merge: got d=%h err=%b ok=%0d want d=%h err=%b",
               rd, er, ok, e.d, e.e);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; bit ok; exp_t e;
    logic [31:0] addrs [5];
    logic        wes   [5];
    addrs = '{B + 32'h3FC, B + 32'h2, B + 32'h400, B + 32'h3FC, 32'h0FFFFFFC};
    wes   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_q.push_back('{d: 32'h0, e: 1'b0});
    exp_q.push_back('{d: 32'h0, e: 1'b1});
    exp_q.push_back('{d: 32'h0, e: 1'b1});
    exp_q.push_back('{d: 32'h5A5A5A5A, e: 1'b0});
    exp_q.push_back('{d: 32'h0, e: 1'b1});
    for (int i = 0; i < 5; i++) begin
      xfer(1, wes[i], addrs[i], (i == 0) ? 32'h5A5A5A5A : 32'hDEADBEEF,
           4'hF, rd, er, lat, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || rd !== e.d || er !== e.e) begin
        n_bad++;
        $display("FAIL err_case%0d @%h: got d=%h err=%b ok=%0d want d=%h err=%b",
                 i, addrs[i], rd, er, ok, e.d, e.e);
      end
    end
    // An out-of-range write must not alias onto word 0.
    exp_q.push_back('{d: merge(32'h11223344, 32'hAABBCCDD, 4'b0101), e: 1'b0});
    xfer(1, 1'b0, B, 32'h0, 4'h0, rd, er, lat, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || rd !== e.d || er !== e.e) begin
      n_bad++;
      $display("FAIL err_no_alias: got d=%h err=%b want d=%h err=%b",
               rd, er, e.d, e.e);
    end
  endtask

  task automatic test_backpressure();
    exp_t e; int n;
    @(negedge clk);
    acc1 = 0;
    rq_v[1] = 1'b1; rq_we[1] = 1'b0; rq_addr[1] = B + 32'h8;
    rq_be[1] = 4'h0; rs_rdy[1] = 1'b0;
    exp_q.push_back('{d: 32'hCAFEBABE, e: 1'b0});
    n = 0;
    while (!rs_v[1] && n < 50) begin @(negedge clk); n++; end
    e = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (rs_v[1] !== 1'b1 || rs_data[1] !== e.d || rs_err[1] !== e.e ||
          rq_rdy[1] !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold c%0d: got v=%b d=%h err=%b rdy=%b want v=1 d=%h err=%b rdy=0",
                 c, rs_v[1], rs_data[1], rs_err[1], rq_rdy[1], e.d, e.e);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (acc1 != 1) begin
      n_bad++;
      $display("FAIL bp_accepts: got %0d want 1", acc1);
    end
    rs_rdy[1] = 1'b1; rq_v[1] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rq_rdy[1] !== 1'b1 || rs_v[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release: got rdy=%b v=%b want rdy=1 v=0", rq_rdy[1], rs_v[1]);
    end
  endtask

  task automatic test_reset_wait();
    logic [31:0] rd; logic er; int lat; bit ok; int n;
    xfer(1, 1'b1, B + 32'h10, 32'h0BADF00D, 4'hF, rd, er, lat, ok);
    @(negedge clk);
    rq_v[1] = 1'b1; rq_we[1] = 1'b1; rq_addr[1] = B + 32'h10;
    rq_wdata[1] = 32'h12345678; rq_be[1] = 4'hF; rs_rdy[1] = 1'b1;
    n = 0;
    while (!rq_rdy[1] && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    rq_v[1] = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (rq_rdy[0] !== 1'b0 || rq_rdy[1] !== 1'b0 || rs_v[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_async: got rdy0=%b rdy1=%b v1=%b want 0 0 0",
               rq_rdy[0], rq_rdy[1], rs_v[1]);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    xfer(1, 1'b0, B + 32'h10, 32'h0, 4'h0, rd, er, lat, ok);
    n_cmp++;
    if (!ok || rd !== 32'h0BADF00D || er !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_wait_drop: got d=%h err=%b ok=%0d want d=0badf00d err=0",
               rd, er, ok);
    end
  endtask

  task automatic test_reset_resp();
    logic [31:0] rd; logic er; int lat; bit ok; int n;
    xfer(0, 1'b1, B + 32'h10, 32'h0BADF00D, 4'hF, rd, er, lat, ok);
    n_cmp++;
    if (!ok || lat != 1) begin
      n_bad++;
      $display("FAIL w0_latency: got %0d ok=%0d want 1", lat, ok);
    end
    @(negedge clk);
    rq_v[0] = 1'b1; rq_we[0] = 1'b1; rq_addr[0] = B + 32'h10;
    rq_wdata[0] = 32'h12345678; rq_be[0] = 4'hF; rs_rdy[0] = 1'b0;
    n = 0;
    while (!rq_rdy[0] && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    rq_v[0] = 1'b0;
    n = 0;
    while (!rs_v[0] && n < 50) begin @(negedge clk); n++; end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (rs_v[0] !== 1'b0 || rq_rdy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_resp_clear: got v=%b rdy=%b want 0 0", rs_v[0], rq_rdy[0]);
    end
    @(negedge clk);
    rst = 1'b1; rs_rdy[0] = 1'b1;
    @(negedge clk);
    xfer(0, 1'b0, B + 32'h10, 32'h0, 4'h0, rd, er, lat, ok);
    n_cmp++;
    if (!ok || rd !== 32'h12345678 || er !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_resp_keep: got d=%h err=%b ok=%0d want d=12345678 err=0",
               rd, er, ok);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat; bit ok; exp_t e;
    int acc_t [$];
    int sent, got, t;
    bit pend;
    for (int i = 0; i < 4; i++)
      xfer(0, 1'b1, B + 32'h20 + 32'(4*i), 32'hA0000000 + 32'(i), 4'hF,
           rd, er, lat, ok);
    exp_q.delete();
    sent = 0; got = 0; t = 0; pend = 1'b0;
    @(negedge clk);
    rs_rdy[0] = 1'b1; rq_we[0] = 1'b0; rq_addr[0] = B + 32'h20; rq_v[0] = 1'b1;
    while (got < 4 && t < 40) begin
      if (pend) begin
        pend = 1'b0;
        if (sent == 4) rq_v[0] = 1'b0;
        else rq_addr[0] = B + 32'h20 + 32'(4*sent);
      end
      if (rs_v[0]) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (rs_data[0] !== e.d || rs_err[0] !== e.e) begin
          n_bad++;
          $display("FAIL b2b_data%0d: got d=%h err=%b want d=%h err=%b",
                   got, rs_data[0], rs_err[0], e.d, e.e);
        end
        got++;
      end
      if (rq_v[0] && rq_rdy[0]) begin
        pend = 1'b1;
        acc_t.push_back(t);
        exp_q.push_back('{d: 32'hA0000000 + 32'(sent), e: 1'b0});
        sent++;
      end
      @(negedge clk);
      t++;
    end
    rq_v[0] = 1'b0;
    n_cmp++;
    if (got != 4 || acc_t.size() != 4) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d rsps %0d accepts want 4 4", got, acc_t.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        n_cmp++;
        if (acc_t[i] - acc_t[i-1] != 2) begin
          n_bad++;
          $display("FAIL b2b_spacing%0d: got %0d want 2", i, acc_t[i] - acc_t[i-1]);
        end
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rq_v[s] = 1'b0; rq_we[s] = 1'b0; rq_addr[s] = '0;
      rq_wdata[s] = '0; rq_be[s] = '0; rs_rdy[s] = 1'b0;
    end
    rst = 1'b0;
    test_reset();
    test_write_read();
    test_byte_en();
    test_errors();
    test_backpressure();
    test_reset_wait();
    test_reset_resp();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
